// File: rtl/solution_packer.sv
// Serialises a solved board (header byte, then row-major bitmap bytes) towards uart_tx
// using a send/tx_done handshake, and pulses done once the last byte is acknowledged.
module solution_packer #(
    parameter int MAX_ROWS = 11,
    parameter int MAX_COLS = 11
) (
    input  logic                           clk_50mhz,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0]   solution,
    input  logic [$clog2(MAX_ROWS)-1:0]    m,
    input  logic [$clog2(MAX_COLS)-1:0]    n,
    input  logic                           tx_done,
    output logic                           send,
    output logic [7:0]                     byte_out,
    output logic                           done
);

    localparam int NCELL = MAX_ROWS * MAX_COLS;
    localparam int IW    = $clog2(NCELL);
    localparam int BPR   = (MAX_COLS + 7) / 8;
    localparam int RW    = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int KW    = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       r_state;
    logic [NCELL-1:0] r_sol;
    logic [3:0]       r_m;
    logic [3:0]       r_n;
    logic [RW-1:0]    r_row;
    logic [KW-1:0]    r_k;
    logic             r_hdr;
    logic             r_send;
    logic [7:0]       r_byte;
    logic             r_done;

    logic [3:0]       w_m_in;
    logic [3:0]       w_n_in;
    logic [1:0]       w_bpr;
    logic             w_more;
    logic [RW-1:0]    w_nrow;
    logic [KW-1:0]    w_nk;
    logic [7:0]       w_nxt_byte;

    function automatic logic [3:0] clamp4(input logic [3:0] v, input int lim);
        return (int'(v) > lim) ? 4'(lim) : v;
    endfunction

    // Columns at or beyond the board width are padded with zeros.
    function automatic logic [7:0] row_byte(input logic [NCELL-1:0] sol, input int row,
                                            input int k, input int ncols);
        logic [7:0]    b;
        logic [IW-1:0] idx;
        int            col;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            col = 8 * k + i;
            if (col < ncols && col < MAX_COLS) begin
                idx  = IW'(row * MAX_COLS + col);
                b[i] = sol[idx];
            end
        end
        return b;
    endfunction

    always_comb begin
        w_m_in = clamp4(4'(m), MAX_ROWS);
        w_n_in = clamp4(4'(n), MAX_COLS);
        w_bpr  = 2'(({1'b0, r_n} + 5'd7) >> 3);
        w_more = 1'b0;
        w_nrow = r_row;
        w_nk   = r_k;
        // Position of the byte that follows the one just acknowledged.
        if (r_hdr) begin
            w_more = (r_m != 4'd0) && (r_n != 4'd0);
            w_nrow = '0;
            w_nk   = '0;
        end else if (int'(r_k) + 1 < int'(w_bpr)) begin
            w_more = 1'b1;
            w_nk   = r_k + 1'b1;
        end else if (int'(r_row) + 1 < int'(r_m)) begin
            w_more = 1'b1;
            w_nrow = r_row + 1'b1;
            w_nk   = '0;
        end
        w_nxt_byte = row_byte(r_sol, int'(w_nrow), int'(w_nk), int'(r_n));
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_m     <= 4'd0;
            r_n     <= 4'd0;
            r_row   <= '0;
            r_k     <= '0;
            r_hdr   <= 1'b0;
            r_send  <= 1'b0;
            r_byte  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_send <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_m     <= w_m_in;
                        r_n     <= w_n_in;
                        r_row   <= '0;
                        r_k     <= '0;
                        r_hdr   <= 1'b1;
                        r_byte  <= {w_m_in, w_n_in};
                        r_send  <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: r_state <= S_WAIT;
                S_WAIT: begin
                    if (tx_done) begin
                        if (w_more) begin
                            r_row   <= w_nrow;
                            r_k     <= w_nk;
                            r_hdr   <= 1'b0;
                            r_byte  <= w_nxt_byte;
                            r_send  <= 1'b1;
                            r_state <= S_SEND;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bitmap is captured only on an accepted start, so it stays frozen for the whole frame.
    always_ff @(posedge clk_50mhz) begin
        if (!rst && r_state == S_IDLE && valid_in) begin
            r_sol <= solution;
        end
    end

    assign send     = r_send;
    assign byte_out = r_byte;
    assign done     = r_done;

endmodule

// File: tb/tb_solution_packer.sv
// Randomised bench for solution_packer: a uart_tx responder drives tx_done and the
// observed byte stream is compared against a queue-based reference of the frame format.
module tb_solution_packer;

    localparam int MR     = 11;
    localparam int MC     = 11;
    localparam int NC     = MR * MC;
    localparam int BUDGET = 600;

    logic          clk_50mhz = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [NC-1:0] solution;
    logic [3:0]    m;
    logic [3:0]    n;
    logic          tx_done;
    logic          send;
    logic [7:0]    byte_out;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    logic [NC-1:0] ones_sol;
    logic [NC-1:0] chk_sol;

    always #10 clk_50mhz = ~clk_50mhz;

    solution_packer #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .valid_in  (valid_in),
        .solution  (solution),
        .m         (m),
        .n         (n),
        .tx_done   (tx_done),
        .send      (send),
        .byte_out  (byte_out),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] rand_sol();
        logic [NC-1:0] s;
        for (int i = 0; i < NC; i++) s[i] = 1'($urandom_range(0, 1));
        return s;
    endfunction

    // Reference frame: header with clamped dims, then ceil(n/8) bytes per row.
    task automatic build_model(input logic [NC-1:0] sol, input int mi, input int ni);
        int mc, nc, nb, c;
        logic [7:0] v;
        mc = (mi > MR) ? MR : mi;
        nc = (ni > MC) ? MC : ni;
        nb = (nc + 7) / 8;
        exp_q.delete();
        exp_q.push_back(8'(mc * 16 + nc));
        for (int r = 0; r < mc; r++) begin
            for (int k = 0; k < nb; k++) begin
                v = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    c = 8 * k + i;
                    if (c < nc) v[i] = sol[r * MC + c];
                end
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic run_frame(input logic [NC-1:0] sol, input int mi, input int ni, input int lat,
                             input bit spur, input bit busy, input int rst_ack, input string nm);
        int acks, dones, last_send, ack_cyc, pend_cyc, rst_cyc, done_cyc, cyc;
        bit pending;
        logic [7:0] held, b;
        logic s, d;
        acks = 0; dones = 0; last_send = -1; ack_cyc = -100; pend_cyc = 0;
        rst_cyc = -100; done_cyc = 0; pending = 1'b0; held = 8'h00;
        got_q.delete();
        build_model(sol, mi, ni);
        @(negedge clk_50mhz);
        solution = sol; m = 4'(mi); n = 4'(ni); valid_in = 1'b1;
        for (cyc = 1; cyc < BUDGET; cyc++) begin
            @(negedge clk_50mhz);
            valid_in = 1'b0; tx_done = 1'b0; rst = 1'b0;
            solution = ~sol; m = 4'($urandom); n = 4'($urandom);
            s = send; d = done; b = byte_out;
            if (cyc == 1) chk({nm, "_hdr_lat"}, 32'(s), 32'd1);
            if (cyc == ack_cyc + 1 && rst_cyc < 0) chk({nm, "_ack_next"}, 32'(s | d), 32'd1);
            if (s || d) chk({nm, "_excl"}, 32'(s & d), 32'd0);
            if (pending && !s) chk({nm, "_hold"}, 32'(b), 32'(held));
            if (rst_cyc >= 0) begin
                if (cyc == rst_cyc + 1) begin
                    chk({nm, "_rst_send"}, 32'(s), 32'd0);
                    chk({nm, "_rst_byte"}, 32'(b), 32'd0);
                    chk({nm, "_rst_done"}, 32'(d), 32'd0);
                end else begin
                    chk({nm, "_rst_quiet"}, 32'(s | d), 32'd0);
                end
                if (cyc >= rst_cyc + 6) break;
                continue;
            end
            if (s) begin
                got_q.push_back(b);
                if (last_send >= 0) chk({nm, "_gap"}, 32'(cyc - last_send), 32'(lat + 1));
                last_send = cyc; pending = 1'b1; held = b; pend_cyc = cyc;
                if (spur) tx_done = 1'b1;
            end else if (pending && cyc == pend_cyc + lat) begin
                tx_done = 1'b1; pending = 1'b0; acks++; ack_cyc = cyc;
            end
            if (d) begin dones++; done_cyc = cyc; end
            if (rst_ack > 0 && acks == rst_ack && cyc == ack_cyc + 1) begin
                rst = 1'b1; rst_cyc = cyc; pending = 1'b0;
            end
            if (busy && cyc == 6) begin
                valid_in = 1'b1; solution = rand_sol(); m = 4'd3; n = 4'd3;
            end
            if (dones > 0 && cyc >= done_cyc + 4) break;
        end
        valid_in = 1'b0; tx_done = 1'b0; rst = 1'b0;
        if (rst_ack > 0) begin
            chk({nm, "_rst_bytes"}, 32'(got_q.size()), 32'(rst_ack + 1));
            chk({nm, "_rst_dones"}, 32'(dones), 32'd0);
        end else begin
            chk({nm, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                chk($sformatf("%s_b%0d", nm, i),
                    (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
            chk({nm, "_dones"}, 32'(dones), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; tx_done = 1'b0; solution = '0; m = 4'd0; n = 4'd0;
        ones_sol = '1;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++)
                chk_sol[r * MC + c] = ((r + c) % 2 == 0);
        repeat (3) @(negedge clk_50mhz);
        chk("reset_send", 32'(send), 32'd0);
        chk("reset_byte", 32'(byte_out), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        @(negedge clk_50mhz); tx_done = 1'b1;
        @(negedge clk_50mhz); tx_done = 1'b0;
        chk("idle_txdone_send", 32'(send), 32'd0);
        chk("idle_txdone_done", 32'(done), 32'd0);

        run_frame(ones_sol, 11, 11, 3, 1'b0, 1'b0, 0, "all1");
        chk("all1_n", 32'(got_q.size()), 32'd23);
        chk("all1_hdr", 32'(got_q[0]), 32'hBB);
        chk("all1_b21", 32'(got_q[21]), 32'hFF);
        chk("all1_b22", 32'(got_q[22]), 32'h07);

        run_frame(chk_sol, 3, 5, 2, 1'b0, 1'b0, 0, "chk");
        chk("chk_b0", 32'(got_q[0]), 32'h35);
        chk("chk_b1", 32'(got_q[1]), 32'h15);
        chk("chk_b2", 32'(got_q[2]), 32'h0A);
        chk("chk_b3", 32'(got_q[3]), 32'h15);

        run_frame(rand_sol(), 0, 5, 2, 1'b0, 1'b0, 0, "empty");
        chk("empty_hdr", 32'(got_q[0]), 32'h05);

        run_frame(ones_sol, 11, 11, 3, 1'b0, 1'b1, 0, "busy");

        run_frame(ones_sol, 11, 11, 2, 1'b0, 1'b0, 4, "rstmid");
        run_frame(chk_sol, 3, 5, 1, 1'b0, 1'b0, 0, "restart");

        @(negedge clk_50mhz);
        rst = 1'b1; valid_in = 1'b1; solution = ones_sol; m = 4'd11; n = 4'd11;
        @(negedge clk_50mhz);
        rst = 1'b0; valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstvld_quiet", 32'(send | done), 32'd0);
            @(negedge clk_50mhz);
        end

        run_frame(rand_sol(), 11, 11, 1, 1'b0, 1'b0, 0, "zlat");
        run_frame(rand_sol(), 7, 9, 2, 1'b1, 1'b0, 0, "spur");
        run_frame(rand_sol(), 15, 15, 1, 1'b0, 1'b0, 0, "clamp");

        for (int t = 0; t < 10; t++)
            run_frame(rand_sol(), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0, 0,
                      $sformatf("rnd%0d", t));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
